// File: rtl/hash_controller_pkg.sv
// Shared types and constants for the hash round sequencer.
// Opcode encoding, datapath control struct, round counts and round-type codes.
package hash_controller_pkg;

    typedef enum logic [1:0] {
        MD5     = 2'b00,
        SHA_1   = 2'b01,
        SHA_256 = 2'b10
    } opcode_e;

    typedef struct packed {
        logic       enable;
        logic       chunk_done;
        logic [1:0] quad_funct;
        logic [1:0] round_type;
    } c_hash_struct;

    localparam int MD5_ROUNDS    = 64;
    localparam int SHA1_ROUNDS   = 80;
    localparam int SHA256_ROUNDS = 64;

    localparam logic [1:0] RT_FIRST = 2'd0;
    localparam logic [1:0] RT_MID   = 2'd1;
    localparam logic [1:0] RT_LAST  = 2'd2;

    // The unused opcode code 2'b11 runs as SHA-256.
    function automatic opcode_e norm_opcode(input logic [1:0] op);
        return (op == 2'b11) ? SHA_256 : opcode_e'(op);
    endfunction

endpackage

// File: rtl/hash_controller_if.sv
// Job and datapath-control bundle between the job source and hash_controller.
// master = job source / scheduler side, slave = the controller.
interface hash_controller_if #(parameter int CHUNK_W = 16);
    import hash_controller_pkg::*;

    logic               start;
    logic [1:0]         opcode;
    logic [CHUNK_W-1:0] num_chunks;
    logic               wk_valid;
    logic               wk_ready;
    logic               hash_start;
    opcode_e            op_out;
    logic [7:0]         round;
    c_hash_struct       c_hash;
    logic               busy;
    logic               done;

    modport master (
        output start, opcode, num_chunks, wk_valid,
        input  wk_ready, hash_start, op_out, round, c_hash, busy, done
    );

    modport slave (
        input  start, opcode, num_chunks, wk_valid,
        output wk_ready, hash_start, op_out, round, c_hash, busy, done
    );

endinterface

// File: rtl/hash_controller_round_decode.sv
// Combinational per-round decode: last-round flag, round function select
// and first/mid/last round type for the current algorithm.
module hash_controller_round_decode
    import hash_controller_pkg::*;
(
    input  opcode_e    i_opcode,
    input  logic [7:0] i_round,
    input  logic       i_in_round,
    output logic       o_last_round,
    output logic [1:0] o_quad_funct,
    output logic [1:0] o_round_type
);

    logic [7:0] w_last_idx;

    always_comb begin
        w_last_idx   = 8'(SHA256_ROUNDS - 1);
        o_quad_funct = 2'd0;
        case (i_opcode)
            MD5: begin
                w_last_idx   = 8'(MD5_ROUNDS - 1);
                o_quad_funct = i_round[5:4];
            end
            SHA_1: begin
                w_last_idx = 8'(SHA1_ROUNDS - 1);
                if (i_round < 8'd20)
                    o_quad_funct = 2'd0;
                else if (i_round < 8'd40)
                    o_quad_funct = 2'd1;
                else if (i_round < 8'd60)
                    o_quad_funct = 2'd2;
                else
                    o_quad_funct = 2'd3;
            end
            default: ;
        endcase

        o_last_round = (i_round == w_last_idx);

        if (!i_in_round)
            o_round_type = RT_FIRST;
        else if (i_round == 8'd0)
            o_round_type = RT_FIRST;
        else if (o_last_round)
            o_round_type = RT_LAST;
        else
            o_round_type = RT_MID;
    end

endmodule

// File: rtl/hash_controller.sv
// Multi-chunk sequencer for the shared MD5/SHA-1/SHA-256 round datapath.
//   state   | meaning
//   IDLE    | waiting for start; latches opcode and chunk count
//   INIT    | one-cycle datapath init pulse, round cleared
//   ROUND   | one round per cycle while wk_valid, stalls otherwise
//   FINAL   | chunk_done pulse, chunk counter decrement, next chunk or finish
//   DONE    | one-cycle done pulse, busy already low
module hash_controller
    import hash_controller_pkg::*;
#(
    parameter int CHUNK_W = 16
)
(
    input  logic             clk,
    input  logic             reset_n,
    hash_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_e;

    localparam logic [CHUNK_W-1:0] ONE_CHUNK = {{(CHUNK_W-1){1'b0}}, 1'b1};

    state_e             r_state,  w_state_nxt;
    opcode_e            r_opcode, w_opcode_nxt;
    logic [7:0]         r_round,  w_round_nxt;
    logic [CHUNK_W-1:0] r_chunks, w_chunks_nxt;

    logic       w_enable;
    logic       w_chunk_done;
    logic       w_hash_start;
    logic       w_busy;
    logic       w_done;
    logic       w_last_round;
    logic [1:0] w_quad_funct;
    logic [1:0] w_round_type;

    hash_controller_round_decode u_round_decode (
        .i_opcode     (r_opcode),
        .i_round      (r_round),
        .i_in_round   (r_state == S_ROUND),
        .o_last_round (w_last_round),
        .o_quad_funct (w_quad_funct),
        .o_round_type (w_round_type)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_opcode <= SHA_256;
            r_round  <= 8'd0;
            r_chunks <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_opcode <= w_opcode_nxt;
            r_round  <= w_round_nxt;
            r_chunks <= w_chunks_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_opcode_nxt = r_opcode;
        w_round_nxt  = r_round;
        w_chunks_nxt = r_chunks;
        w_enable     = 1'b0;
        w_chunk_done = 1'b0;
        w_hash_start = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_opcode_nxt = norm_opcode(bus.opcode);
                    w_chunks_nxt = (bus.num_chunks == '0) ? ONE_CHUNK : bus.num_chunks;
                    w_round_nxt  = 8'd0;
                    w_state_nxt  = S_INIT;
                end
            end
            S_INIT: begin
                w_hash_start = 1'b1;
                w_busy       = 1'b1;
                w_round_nxt  = 8'd0;
                w_state_nxt  = S_ROUND;
            end
            S_ROUND: begin
                w_busy   = 1'b1;
                w_enable = bus.wk_valid;
                if (bus.wk_valid) begin
                    // The last round index is held through FINAL, never wrapped.
                    if (w_last_round)
                        w_state_nxt = S_FINAL;
                    else
                        w_round_nxt = r_round + 8'd1;
                end
            end
            S_FINAL: begin
                w_busy       = 1'b1;
                w_chunk_done = 1'b1;
                w_round_nxt  = 8'd0;
                if (r_chunks != '0)
                    w_chunks_nxt = r_chunks - ONE_CHUNK;
                if (r_chunks > ONE_CHUNK)
                    w_state_nxt = S_ROUND;
                else
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.wk_ready   = w_enable;
    assign bus.hash_start = w_hash_start;
    assign bus.op_out     = r_opcode;
    assign bus.round      = r_round;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.c_hash     = c_hash_struct'({w_enable, w_chunk_done, w_quad_funct, w_round_type});

endmodule

// File: tb/tb_hash_controller.sv
// Directed bench for hash_controller: pulse schedule scoreboard plus a
// per-round model of round, enable, quad_funct and round_type.
module tb_hash_controller;
    import hash_controller_pkg::*;

    localparam int CW = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    hash_controller_if #(.CHUNK_W(CW)) bus ();

    hash_controller #(.CHUNK_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string tag;
        int    cyc;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // Compares a pulse whenever it is seen or the schedule says it is due.
    task automatic chk_pulse(input string tag, input logic obs, input int cyc, output bit hit);
        logic want;
        want = (exp_q.size() > 0) && (exp_q[0].cyc == cyc) && (exp_q[0].tag == tag);
        hit  = want;
        if (obs !== 1'b0 || want)
            chk($sformatf("%s@%0d", tag, cyc), {31'd0, obs}, {31'd0, want});
        if (want)
            void'(exp_q.pop_front());
    endtask

    function automatic logic [1:0] exp_quad(input logic [1:0] op, input int r);
        logic [7:0] rr;
        rr = 8'(r);
        if (op == 2'b00) return rr[5:4];
        if (op == 2'b01) return 2'(r / 20);
        return 2'd0;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},       {31'd0, bus.busy},       32'd0);
        chk({tag, "_done"},       {31'd0, bus.done},       32'd0);
        chk({tag, "_hash_start"}, {31'd0, bus.hash_start}, 32'd0);
        chk({tag, "_wk_ready"},   {31'd0, bus.wk_ready},   32'd0);
        chk({tag, "_round"},      {24'd0, bus.round},      32'd0);
        chk({tag, "_c_hash"},     {26'd0, bus.c_hash},     32'd0);
        chk({tag, "_op_out"},     {30'd0, bus.op_out},     32'd2);
    endtask

    task automatic run_job(input logic [1:0] op, input int nc, input int stall_at,
                           input int stall_len, input bit poke, input int abort_at);
        int rounds, n, t, last, cr, stalls, left;
        bit in_round, hit;
        logic [1:0] eop;
        eop    = (op == 2'b11) ? 2'b10 : op;
        rounds = (eop == 2'b01) ? 80 : 64;
        n      = (nc == 0) ? 1 : nc;
        exp_q.delete();
        exp_q.push_back('{"hash_start", 1});
        t = 1;
        for (int c = 0; c < n; c++) begin
            t += rounds + 1 + ((c == 0 && stall_at >= 0) ? stall_len : 0);
            exp_q.push_back('{"chunk_done", t});
        end
        last = t + 1;
        exp_q.push_back('{"done", last});
        cr = 0; stalls = 0; left = n; in_round = 1'b0;

        for (int cyc = 0; cyc <= last + 1; cyc++) begin
            @(posedge clk);
            #1;
            bus.start      = (cyc == 0) || (poke && (cyc == 30 || cyc == last));
            bus.opcode     = (cyc == 0) ? op : 2'b00;
            bus.num_chunks = (cyc == 0) ? CW'(nc) : 16'd7;
            bus.wk_valid   = !(in_round && cr == stall_at && stalls < stall_len);
            @(negedge clk);

            if (in_round) begin
                chk("round",      {24'd0, bus.round},             32'(cr));
                chk("enable",     {31'd0, bus.c_hash.enable},     {31'd0, bus.wk_valid});
                chk("wk_ready",   {31'd0, bus.wk_ready},          {31'd0, bus.wk_valid});
                chk("quad_funct", {30'd0, bus.c_hash.quad_funct}, {30'd0, exp_quad(eop, cr)});
                chk("round_type", {30'd0, bus.c_hash.round_type},
                    (cr == 0) ? 32'd0 : (cr == rounds - 1) ? 32'd2 : 32'd1);
                if (!bus.wk_valid)
                    stalls++;
                else if (cr == rounds - 1)
                    in_round = 1'b0;
                else
                    cr++;
            end else begin
                chk("idle_enable",     {31'd0, bus.c_hash.enable},     32'd0);
                chk("idle_round_type", {30'd0, bus.c_hash.round_type}, 32'd0);
            end

            chk("busy", {31'd0, bus.busy}, (cyc >= 1 && cyc < last) ? 32'd1 : 32'd0);

            chk_pulse("hash_start", bus.hash_start, cyc, hit);
            if (hit) begin
                in_round = 1'b1;
                cr = 0;
                chk("op_out", {30'd0, bus.op_out}, {30'd0, eop});
            end
            chk_pulse("chunk_done", bus.c_hash.chunk_done, cyc, hit);
            if (hit) begin
                left--;
                if (left > 0) begin
                    in_round = 1'b1;
                    cr = 0;
                end
            end
            chk_pulse("done", bus.done, cyc, hit);

            if (cyc == abort_at) begin
                bus.start = 1'b0;
                #1 reset_n = 1'b0;
                #1 chk_reset_outputs("async_rst");
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("rst_no_done", {31'd0, bus.done}, 32'd0);
                    chk("rst_no_busy", {31'd0, bus.busy}, 32'd0);
                end
                reset_n = 1'b1;
                exp_q.delete();
                return;
            end
        end
        chk("sched_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.opcode     = 2'b00;
        bus.num_chunks = '0;
        bus.wk_valid   = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        run_job(2'b10, 1, -1, 0, 1'b0, -1);   // SHA-256, single chunk
        run_job(2'b01, 1, -1, 0, 1'b0, -1);   // SHA-1, 80 rounds
        run_job(2'b00, 3, -1, 0, 1'b0, -1);   // MD5, three chunks
        run_job(2'b10, 1, 10, 5, 1'b0, -1);   // 5-cycle word stall at round 10
        run_job(2'b11, 0, -1, 0, 1'b1, -1);   // opcode 11, zero chunks, stray starts
        run_job(2'b10, 1, -1, 0, 1'b0, 32);   // reset during round 30
        run_job(2'b01, 2, -1, 0, 1'b0, -1);   // recovery job

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
